// File: rtl/result_binarizer.sv
// result_binarizer
// Captures the N*N accumulator results of the PE grid when a tile completes.
// Streams them row-major as binarized 8-bit pixels to the frame/pixel writer.
// This frees the PE grid to start the next tile while the snapshot drains.
//
// Handshake: a pixel transfers on a rising edge where o_valid && i_ready.
// o_valid never depends on i_ready. While o_valid is high and i_ready is low,
// o_pixel, o_row, o_col and o_last hold their values. i_ready is don't-care
// whenever o_valid is low.
module result_binarizer #(
    parameter int N     = 4,
    parameter int ACC_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_start,
    input  logic [N*N*ACC_W-1:0]   i_y,
    input  logic [ACC_W-1:0]       i_threshold,
    output logic                   o_busy,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [7:0]             o_pixel,
    output logic [$clog2(N)-1:0]   o_row,
    output logic [$clog2(N)-1:0]   o_col,
    output logic                   o_last,
    output logic                   o_done
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int RC_W  = $clog2(N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [RC_W-1:0]  LAST_COL = RC_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] cap_q [NN];
    logic [ACC_W-1:0] thr_q;
    logic [IDX_W-1:0] idx_q;
    // Row/column counters kept alongside idx so that N need not be a power of two.
    logic [RC_W-1:0]  row_q;
    logic [RC_W-1:0]  col_q;

    // Tile FSM: capture on start, walk the snapshot one pixel per accepted transfer, pulse done.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= IDLE;
            thr_q <= '0;
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
            for (int i = 0; i < NN; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        for (int i = 0; i < NN; i++) begin
                            cap_q[i] <= i_y[i*ACC_W +: ACC_W];
                        end
                        thr_q <= i_threshold;
                        idx_q <= '0;
                        row_q <= '0;
                        col_q <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (i_ready) begin
                        if (idx_q == LAST_IDX) begin
                            // Park the counters at zero so row/col read 0 outside the stream.
                            idx_q <= '0;
                            row_q <= '0;
                            col_q <= '0;
                            state <= DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            if (col_q == LAST_COL) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode purely from registered state, so they cannot glitch with i_ready.
    always_comb begin
        o_valid = (state == STREAM);
        o_busy  = (state != IDLE);
        o_done  = (state == DONE);
        o_row   = row_q;
        o_col   = col_q;
        o_last  = (state == STREAM) && (idx_q == LAST_IDX);
        o_pixel = ((state == STREAM) && (cap_q[idx_q] >= thr_q)) ? 8'hFF : 8'h00;
    end

endmodule

// File: tb/tb_result_binarizer.sv
// tb_result_binarizer
// Directed tile scenarios with randomized data and handshake.
// Expected pixels come from a per-tile array model: value >= threshold -> 8'hFF.
// Row and column are derived from the running transfer count.
module tb_result_binarizer;

    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int NN    = N * N;

    logic                 clk = 1'b0;
    logic                 arst;
    logic                 start;
    logic [NN*ACC_W-1:0]  y;
    logic [ACC_W-1:0]     thr;
    logic                 ready;
    logic                 busy;
    logic                 valid;
    logic [7:0]           pixel;
    logic [1:0]           row;
    logic [1:0]           col;
    logic                 last;
    logic                 done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ACC_W-1:0] vals [NN];
    logic [ACC_W-1:0] thr_m;
    logic [7:0]       exp_q [$];

    result_binarizer #(.N(N), .ACC_W(ACC_W)) dut (
        .i_clk       (clk),
        .i_arst      (arst),
        .i_start     (start),
        .i_y         (y),
        .i_threshold (thr),
        .o_busy      (busy),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_pixel     (pixel),
        .o_row       (row),
        .o_col       (col),
        .o_last      (last),
        .o_done      (done)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_row"},   32'(row),   32'd0);
        chk({tag, "_col"},   32'(col),   32'd0);
        chk({tag, "_last"},  32'(last),  32'd0);
    endtask

    // model: expected pixel stream for the tile held in vals/thr_m
    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back((vals[i] >= thr_m) ? 8'hFF : 8'h00);
        end
    endtask

    // driver: present tile data and pulse start for one cycle (called at negedge)
    task automatic launch();
        for (int i = 0; i < NN; i++) begin
            y[i*ACC_W +: ACC_W] = vals[i];
        end
        thr   = thr_m;
        build_expected();
        ready = 1'($urandom_range(0, 1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // driver + checker: drain one tile. mode 0 = ready high, 1 = 1010.., 2 = random.
    // inject_at >= 0 pulses start with junk data while that pixel is presented.
    task automatic stream_tile(input int mode, input int inject_at);
        int         n = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] pp = 8'h00;
        logic [1:0] pr = 2'd0;
        logic [1:0] pc = 2'd0;
        while (n < NN && cyc < 200) begin
            chk("valid", 32'(valid), 32'd1);
            chk("busy",  32'(busy),  32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (stalled) begin
                chk("stall_pixel", 32'(pixel), 32'(pp));
                chk("stall_row",   32'(row),   32'(pr));
                chk("stall_col",   32'(col),   32'(pc));
            end
            chk("pixel", 32'(pixel), 32'(exp_q[0]));
            chk("row",   32'(row),   n / N);
            chk("col",   32'(col),   n % N);
            chk("last",  32'(last),  32'(n == NN - 1));
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 2) == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            start = (n == inject_at);
            // captured values must be immune to later input changes
            for (int i = 0; i < NN; i++) begin
                y[i*ACC_W +: ACC_W] = $urandom;
            end
            thr = $urandom;
            if (ready) begin
                void'(exp_q.pop_front());
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pp = pixel;
                pr = row;
                pc = col;
            end
            @(negedge clk);
            cyc++;
        end
        if (n < NN) chk("stream_timeout", n, NN);
        start = 1'b0;
        ready = 1'($urandom_range(0, 1));
        chk("done_pulse", 32'(done),  32'd1);
        chk("done_valid", 32'(valid), 32'd0);
        chk("done_busy",  32'(busy),  32'd1);
        chk("done_last",  32'(last),  32'd0);
        @(negedge clk);
        chk("after_done",  32'(done),  32'd0);
        chk("after_busy",  32'(busy),  32'd0);
        chk("after_valid", 32'(valid), 32'd0);
        ready = 1'b0;
    endtask

    task automatic rand_tile(input logic [ACC_W-1:0] lo, input logic [ACC_W-1:0] hi);
        for (int i = 0; i < NN; i++) begin
            vals[i] = $urandom_range(hi, lo);
        end
        thr_m = $urandom_range(hi, lo);
        // force at least one equality case
        vals[$urandom_range(NN - 1, 0)] = thr_m;
    endtask

    initial begin
        // reset
        arst  = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        y     = '0;
        thr   = '0;
        #1;
        chk_idle_outputs("reset");
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // ramp data, thr=75, continuous ready
        for (int i = 0; i < NN; i++) vals[i] = 32'(i * 10);
        thr_m = 32'd75;
        launch();
        stream_tile(0, -1);

        // same data, thr=80 hits equality at idx 8, alternating ready
        thr_m = 32'd80;
        launch();
        stream_tile(1, -1);

        // start pulse mid-stream at pixel 5 must be ignored
        thr_m = 32'd45;
        launch();
        stream_tile(0, 5);
        // new tile after done
        for (int i = 0; i < NN; i++) vals[i] = 32'(1000 - i * 37);
        thr_m = 32'd700;
        launch();
        stream_tile(2, 3);

        // thr=0 -> all FF
        for (int i = 0; i < NN; i++) vals[i] = $urandom;
        vals[0] = 32'd0;
        thr_m = 32'd0;
        launch();
        stream_tile(2, -1);

        // thr=max with all values max-1 -> all 00
        for (int i = 0; i < NN; i++) vals[i] = 32'hFFFF_FFFE;
        thr_m = 32'hFFFF_FFFF;
        launch();
        stream_tile(0, -1);

        // randomized tiles
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) rand_tile(32'd0, 32'd20);
            else            rand_tile(32'hFFFF_FF00, 32'hFFFF_FFFF);
            launch();
            stream_tile(2, (t == 3) ? 7 : -1);
        end

        // reset during pixel 9 with ready low
        rand_tile(32'd0, 32'd50);
        launch();
        for (int n = 0; n < 9; n++) begin
            chk("pre_rst_pixel", 32'(pixel), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            ready = 1'b1;
            @(negedge clk);
        end
        chk("pre_rst_row", 32'(row), 32'd2);
        chk("pre_rst_col", 32'(col), 32'd1);
        ready = 1'b0;
        arst  = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        @(negedge clk);
        arst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ready = 1'($urandom_range(0, 1));
            chk("rst_no_done",  32'(done),  32'd0);
            chk("rst_no_valid", 32'(valid), 32'd0);
            chk("rst_no_busy",  32'(busy),  32'd0);
            @(negedge clk);
        end
        ready = 1'b0;

        // normal tile after abort
        rand_tile(32'd100, 32'd140);
        launch();
        stream_tile(1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
